// File: rtl/ball_pkg.sv
// Shared state codes, direction encodings and default geometry for the ball mover.
package ball_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ERASE_LOAD = 3'd1;
    localparam state_t ST_ERASE_RUN  = 3'd2;
    localparam state_t ST_MOVE       = 3'd3;
    localparam state_t ST_DRAW_LOAD  = 3'd4;
    localparam state_t ST_DRAW_RUN   = 3'd5;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_BALL_SIZE = 4;
    localparam int DEF_PADDLE_Y = 116;
    localparam int DEF_PADDLE_W = 20;
    localparam int DEF_START_X = 78;
    localparam int DEF_START_Y = 100;
    localparam logic [2:0] DEF_BALL_COLOUR = 3'b111;
    localparam logic [2:0] DEF_BG_COLOUR = 3'b000;

endpackage

// File: rtl/ball_step.sv
// Combinational next position/direction for one frame: sticky flips first,
// then wall and paddle bounces, then loss detection and the one-pixel step.
module ball_step
    import ball_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PADDLE_Y  = DEF_PADDLE_Y,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y
) (
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       dx,
    input  logic       dy,
    input  logic       flip_x,
    input  logic       flip_y,
    input  logic [7:0] paddle_x,
    output logic [7:0] next_x,
    output logic [6:0] next_y,
    output logic       next_dx,
    output logic       next_dy,
    output logic       lost
);

    localparam logic [8:0] SW9 = 9'(SCREEN_W);
    localparam logic [8:0] SH9 = 9'(SCREEN_H);
    localparam logic [8:0] BS9 = 9'(BALL_SIZE);
    localparam logic [8:0] PY9 = 9'(PADDLE_Y);
    localparam logic [8:0] PW9 = 9'(PADDLE_W);

    logic [8:0] x9, y9, px9;
    logic       dx_f, dy_f, dx_w, dy_w, on_paddle;

    assign x9  = {1'b0, x};
    assign y9  = {2'b00, y};
    assign px9 = {1'b0, paddle_x};

    assign on_paddle = (y9 + BS9 == PY9) && (x9 + BS9 - 9'd1 >= px9) && (x9 <= px9 + PW9 - 9'd1);

    always_comb begin
        dx_f = dx ^ flip_x;
        dy_f = dy ^ flip_y;

        dx_w = dx_f;
        if (dx_f == DIR_NEG && x9 == 9'd0)
            dx_w = DIR_POS;
        else if (dx_f == DIR_POS && x9 + BS9 == SW9)
            dx_w = DIR_NEG;

        dy_w = dy_f;
        lost = 1'b0;
        if (dy_f == DIR_NEG && y9 == 9'd0)
            dy_w = DIR_POS;
        else if (dy_f == DIR_POS && y9 + BS9 == SH9)
            lost = 1'b1;
        else if (dy_f == DIR_POS && on_paddle)
            dy_w = DIR_NEG;

        if (lost) begin
            next_x  = 8'(START_X);
            next_y  = 7'(START_Y);
            next_dx = DIR_POS;
            next_dy = DIR_NEG;
        end else begin
            next_x  = (dx_w == DIR_POS) ? x + 8'd1 : x - 8'd1;
            next_y  = (dy_w == DIR_POS) ? y + 7'd1 : y - 7'd1;
            next_dx = dx_w;
            next_dy = dy_w;
        end
    end

endmodule

// File: rtl/ball_mover.sv
// Per-frame erase / move / redraw sequencer driving the ball rasteriser handshake.
//   state       | meaning
//   IDLE        | wait for frame_tick
//   ERASE_LOAD  | go pulse, background colour at old position
//   ERASE_RUN   | wait for draw_done of the erase pass
//   MOVE        | register next position/direction, clear brick latches
//   DRAW_LOAD   | go pulse, ball colour at new position
//   DRAW_RUN    | wait for draw_done of the draw pass
module ball_mover
    import ball_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PADDLE_Y  = DEF_PADDLE_Y,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y,
    parameter logic [2:0] BALL_COLOUR = DEF_BALL_COLOUR,
    parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] paddle_x,
    input  logic       brick_hit_x,
    input  logic       brick_hit_y,
    input  logic       draw_done,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [6:0] size,
    output logic [2:0] colour,
    output logic       go,
    output logic       draw,
    output logic       busy,
    output logic       ball_lost
);

    state_t     state;
    logic [7:0] x, next_x;
    logic [6:0] y, next_y;
    logic       dx, dy, next_dx, next_dy, step_lost;
    logic       hit_x, hit_y;

    // A hit arriving in the MOVE cycle itself must still be applied there.
    ball_step #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_Y (PADDLE_Y),
        .PADDLE_W (PADDLE_W),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) u_step (
        .x       (x),
        .y       (y),
        .dx      (dx),
        .dy      (dy),
        .flip_x  (hit_x | brick_hit_x),
        .flip_y  (hit_y | brick_hit_y),
        .paddle_x(paddle_x),
        .next_x  (next_x),
        .next_y  (next_y),
        .next_dx (next_dx),
        .next_dy (next_dy),
        .lost    (step_lost)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            x     <= 8'(START_X);
            y     <= 7'(START_Y);
            dx    <= DIR_POS;
            dy    <= DIR_NEG;
            hit_x <= 1'b0;
            hit_y <= 1'b0;
        end else begin
            if (state == ST_MOVE) begin
                hit_x <= 1'b0;
                hit_y <= 1'b0;
                x     <= next_x;
                y     <= next_y;
                dx    <= next_dx;
                dy    <= next_dy;
            end else begin
                hit_x <= hit_x | brick_hit_x;
                hit_y <= hit_y | brick_hit_y;
            end

            case (state)
                ST_IDLE:       if (frame_tick) state <= ST_ERASE_LOAD;
                ST_ERASE_LOAD: state <= ST_ERASE_RUN;
                ST_ERASE_RUN:  if (draw_done) state <= ST_MOVE;
                ST_MOVE:       state <= ST_DRAW_LOAD;
                ST_DRAW_LOAD:  state <= ST_DRAW_RUN;
                ST_DRAW_RUN:   if (draw_done) state <= ST_IDLE;
                default:       state <= ST_IDLE;
            endcase
        end
    end

    assign x_out     = x;
    assign y_out     = y;
    assign size      = 7'(BALL_SIZE);
    assign go        = (state == ST_ERASE_LOAD) || (state == ST_DRAW_LOAD);
    assign draw      = !((state == ST_ERASE_RUN) || (state == ST_DRAW_RUN));
    assign busy      = (state != ST_IDLE);
    assign colour    = ((state == ST_DRAW_LOAD) || (state == ST_DRAW_RUN)) ? BALL_COLOUR : BG_COLOUR;
    assign ball_lost = (state == ST_MOVE) && step_lost;

endmodule

// File: tb/tb_ball_mover.sv
// Bench for ball_mover: transaction-level ball model plus per-cycle output comparison.
module tb_ball_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, brick_hit_x, brick_hit_y, draw_done;
    logic [7:0] paddle_x;
    logic [7:0] x_out;
    logic [6:0] y_out, size;
    logic [2:0] colour;
    logic       go, draw, busy, ball_lost;

    ball_mover dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .paddle_x   (paddle_x),
        .brick_hit_x(brick_hit_x),
        .brick_hit_y(brick_hit_y),
        .draw_done  (draw_done),
        .x_out      (x_out),
        .y_out      (y_out),
        .size       (size),
        .colour     (colour),
        .go         (go),
        .draw       (draw),
        .busy       (busy),
        .ball_lost  (ball_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase of the frame and the ball as signed integers with +/-1 velocity.
    localparam int PH_IDLE = 0, PH_ERASE_GO = 1, PH_ERASE_WAIT = 2,
                   PH_MOVE = 3, PH_DRAW_GO = 4, PH_DRAW_WAIT = 5;
    int ph, mx, my, mvx, mvy;
    bit pend_x, pend_y;

    int er_x, er_y, er_col, dr_x, dr_y, dr_col, lost_cnt;

    task automatic model_reset();
        ph = PH_IDLE; mx = 78; my = 100; mvx = 1; mvy = -1;
        pend_x = 0; pend_y = 0;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic cycle(input bit ft, input bit bx, input bit by, input bit dd, input logic [7:0] px);
        int  vx, vy, nx, ny, p;
        bit  lost;
        @(negedge clk);
        frame_tick = ft; brick_hit_x = bx; brick_hit_y = by; draw_done = dd; paddle_x = px;
        #1;
        p  = int'(px);
        vx = (pend_x | bx) ? -mvx : mvx;
        vy = (pend_y | by) ? -mvy : mvy;
        if (mx + vx < 0 || mx + vx + 4 > 160) vx = -vx;
        if (my + vy < 0) vy = -vy;
        lost = (vy == 1) && (my + 4 == 120);
        if (!lost && vy == 1 && my + 4 == 116 && mx + 3 >= p && mx <= p + 19) vy = -1;
        nx = mx + vx; ny = my + vy;

        check("go", go, (ph == PH_ERASE_GO || ph == PH_DRAW_GO));
        check("draw", draw, !(ph == PH_ERASE_WAIT || ph == PH_DRAW_WAIT));
        check("busy", busy, ph != PH_IDLE);
        check("x_out", x_out, mx);
        check("y_out", y_out, my);
        check("size", size, 4);
        check("ball_lost", ball_lost, (ph == PH_MOVE) && lost);
        if (ph == PH_ERASE_GO || ph == PH_ERASE_WAIT) check("colour_erase", colour, 0);
        if (ph == PH_DRAW_GO || ph == PH_DRAW_WAIT) check("colour_draw", colour, 7);

        if (ph == PH_ERASE_GO) begin er_x = int'(x_out); er_y = int'(y_out); er_col = int'(colour); end
        if (ph == PH_DRAW_GO) begin dr_x = int'(x_out); dr_y = int'(y_out); dr_col = int'(colour); end
        if (ball_lost === 1'b1) lost_cnt++;

        if (ph == PH_MOVE) begin
            pend_x = 0; pend_y = 0;
            if (lost) begin mx = 78; my = 100; mvx = 1; mvy = -1; end
            else begin mx = nx; my = ny; mvx = vx; mvy = vy; end
        end else begin
            pend_x |= bx; pend_y |= by;
        end
        case (ph)
            PH_IDLE:       if (ft) ph = PH_ERASE_GO;
            PH_ERASE_GO:   ph = PH_ERASE_WAIT;
            PH_ERASE_WAIT: if (dd) ph = PH_MOVE;
            PH_MOVE:       ph = PH_DRAW_GO;
            PH_DRAW_GO:    ph = PH_DRAW_WAIT;
            PH_DRAW_WAIT:  if (dd) ph = PH_IDLE;
            default:       ph = PH_IDLE;
        endcase
    endtask

    // One full frame from IDLE; brick requests are pulsed on the first ERASE_RUN cycle.
    task automatic run_frame(input bit bx_req, input bit by_req, input logic [7:0] px, input bit noise);
        int guard, dly;
        bit hit_done, ft, dd, bx, by;
        lost_cnt = 0;
        guard = 0; hit_done = 0;
        dly = $urandom_range(0, 3);
        cycle(1, 0, 0, 0, px);
        while (ph != PH_IDLE && guard < 40) begin
            ft = 0; dd = 0; bx = 0; by = 0;
            if (ph == PH_ERASE_WAIT || ph == PH_DRAW_WAIT) begin
                if (dly == 0) begin dd = 1; dly = $urandom_range(0, 3); end
                else dly--;
            end else if (noise) begin
                dd = ($urandom_range(0, 1) == 1);
            end
            if (noise) begin
                ft = ($urandom_range(0, 1) == 1);
                bx = ($urandom_range(0, 9) == 0);
                by = ($urandom_range(0, 9) == 0);
            end
            if (ph == PH_ERASE_WAIT && !hit_done) begin
                bx |= bx_req; by |= by_req; hit_done = 1;
            end
            cycle(ft, bx, by, dd, px);
            guard++;
        end
        if (ph != PH_IDLE) check("frame_timeout", ph, PH_IDLE);
    endtask

    initial begin
        int t;
        logic [7:0] px;
        reset = 1'b1;
        frame_tick = 0; brick_hit_x = 0; brick_hit_y = 0; draw_done = 0; paddle_x = 8'd200;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_go", go, 0);
        check("rst_draw", draw, 1);
        check("rst_busy", busy, 0);
        check("rst_colour", colour, 0);
        check("rst_lost", ball_lost, 0);
        check("rst_x", x_out, 78);
        check("rst_y", y_out, 100);
        reset = 1'b0;

        run_frame(0, 0, 8'd200, 0);
        check("f1_erase_x", er_x, 78);
        check("f1_erase_y", er_y, 100);
        check("f1_erase_col", er_col, 0);
        check("f1_draw_x", dr_x, 79);
        check("f1_draw_y", dr_y, 99);
        check("f1_draw_col", dr_col, 7);
        cycle(0, 0, 0, 0, 8'd200);
        check("f1_busy_low", busy, 0);

        repeat (77) run_frame(0, 0, 8'd200, 0);
        run_frame(0, 0, 8'd200, 0);
        check("right_wall_x", dr_x, 155);
        check("right_wall_y", dr_y, 21);

        repeat (21) run_frame(0, 0, 8'd200, 0);
        run_frame(0, 0, 8'd200, 0);
        check("top_wall_x", dr_x, 133);
        check("top_wall_y", dr_y, 1);

        repeat (115) run_frame(0, 0, 8'd200, 0);
        run_frame(0, 0, 8'd200, 0);
        check("loss_pulses", lost_cnt, 1);
        check("loss_draw_x", dr_x, 78);
        check("loss_draw_y", dr_y, 100);

        run_frame(0, 1, 8'd200, 0);
        check("brick_y_y", dr_y, 101);
        check("brick_y_x", dr_x, 79);
        repeat (11) run_frame(0, 0, 8'd200, 0);
        run_frame(0, 0, 8'd80, 0);
        check("paddle_y", dr_y, 111);
        check("paddle_x", dr_x, 91);

        run_frame(1, 0, 8'd80, 0);
        check("brick_x_x", dr_x, 90);
        check("brick_x_y", dr_y, 110);
        run_frame(0, 0, 8'd80, 0);
        check("latch_clear_x", dr_x, 89);
        check("latch_clear_y", dr_y, 109);

        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                t = mx - int'($urandom_range(0, 22));
                if (t < 0) t = 0;
                px = t[7:0];
            end else begin
                px = 8'($urandom_range(0, 255));
            end
            repeat ($urandom_range(0, 2))
                cycle(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 1) == 1), px);
            run_frame(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), px, 1);
        end

        cycle(1, 0, 0, 0, 8'd200);
        cycle(0, 0, 0, 0, 8'd200);
        @(negedge clk);
        #1;
        check("mid_run_draw", draw, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_go", go, 0);
        check("mid_rst_draw", draw, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_x", x_out, 78);
        check("mid_rst_y", y_out, 100);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_frame(0, 0, 8'd200, 0);
        check("post_rst_erase_x", er_x, 78);
        check("post_rst_draw_x", dr_x, 79);
        check("post_rst_draw_y", dr_y, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
